// File: rtl/sample_scheduler_if.sv
// sample_scheduler_if: handshake bundle between the sample scheduler and the ADC, SDFT and line writer
interface sample_scheduler_if #(
  parameter int ADC_W = 12,
  parameter int OVR_W = 8
);
  logic             enable;
  logic             adc_start;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] sdft_sample;
  logic             sdft_start;
  logic             sdft_ready;
  logic             line_req;
  logic             line_ack;
  logic             overrun;
  logic [OVR_W-1:0] overrun_count;
  modport master (
    input  enable, adc_valid, adc_data, sdft_ready, line_ack,
    output adc_start, sdft_sample, sdft_start, line_req, overrun, overrun_count
  );
  modport slave (
    output enable, adc_valid, adc_data, sdft_ready, line_ack,
    input  adc_start, sdft_sample, sdft_start, line_req, overrun, overrun_count
  );
endinterface

// File: rtl/sample_scheduler.sv
// sample_scheduler: paces ADC samples into the SDFT and requests waterfall lines; SAMPLE_SCHED_OVERRUN_EN records dropped ticks
module sample_scheduler #(
  parameter int SAMPLE_DIV   = 1250,
  parameter int LINE_SAMPLES = 64,
  parameter int ADC_W        = 12,
  parameter int OVR_W        = 8
) (
  input logic clk,
  input logic reset,
  sample_scheduler_if.master bus
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(LINE_SAMPLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_ADC, START_SDFT, WAIT_SDFT, LINE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] smp_cnt, smp_cnt_nx;
  logic [ADC_W-1:0] sample_nx;
  logic first, tick, done;
  assign tick = bus.enable && div_cnt == DW'(SAMPLE_DIV - 1);
  assign done = state == WAIT_SDFT && !first && bus.sdft_ready;
  always_comb begin
    state_nx   = state;
    smp_cnt_nx = smp_cnt;
    sample_nx  = bus.sdft_sample;
    case (state)
      IDLE:       state_nx = tick ? WAIT_ADC : IDLE;
      WAIT_ADC: begin
        state_nx  = bus.adc_valid ? START_SDFT : WAIT_ADC;
        sample_nx = bus.adc_valid ? bus.adc_data : bus.sdft_sample;
      end
      START_SDFT: state_nx = WAIT_SDFT;
      WAIT_SDFT: begin
        smp_cnt_nx = done ? smp_cnt + SW'(1) : smp_cnt;
        state_nx   = !done ? WAIT_SDFT : smp_cnt == SW'(LINE_SAMPLES - 1) ? LINE : IDLE;
      end
      LINE: begin
        smp_cnt_nx = bus.line_ack ? '0 : smp_cnt;
        state_nx   = bus.line_ack ? IDLE : LINE;
      end
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      smp_cnt         <= '0;
      first           <= 1'b0;
      bus.adc_start   <= 1'b0;
      bus.sdft_start  <= 1'b0;
      bus.line_req    <= 1'b0;
      bus.sdft_sample <= '0;
    end else begin
      state           <= state_nx;
      div_cnt         <= (!bus.enable || tick) ? '0 : div_cnt + DW'(1);
      smp_cnt         <= smp_cnt_nx;
      first           <= state == START_SDFT;
      bus.adc_start   <= state == IDLE && tick;
      bus.sdft_start  <= state_nx == START_SDFT;
      bus.line_req    <= state_nx == LINE;
      bus.sdft_sample <= sample_nx;
    end
  end
`ifdef SAMPLE_SCHED_OVERRUN_EN
  logic drop;
  assign drop = tick && state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.overrun       <= 1'b0;
      bus.overrun_count <= '0;
    end else if (drop) begin
      bus.overrun       <= 1'b1;
      bus.overrun_count <= bus.overrun_count == '1 ? bus.overrun_count : bus.overrun_count + OVR_W'(1);
    end
  end
`else
  assign bus.overrun       = 1'b0;
  assign bus.overrun_count = '0;
`endif
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: randomized responders checked every cycle against a timestamped transaction model
module tb_sample_scheduler;
  localparam int DIV = 20, LS = 4, AW = 12, OW = 2, OMAX = (1 << OW) - 1, N = 3600;
`ifdef SAMPLE_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  sample_scheduler_if #(.ADC_W(AW), .OVR_W(OW)) bus ();
  sample_scheduler #(.SAMPLE_DIV(DIV), .LINE_SAMPLES(LS), .ADC_W(AW), .OVR_W(OW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int run = 0, ph = 0, rdy_from = 0, cnt = 0, e_ocnt = 0, n_adc_dut = 0, n_adc_exp = 0;
  bit e_adc = 0, e_sdft = 0, e_line = 0, e_ovr = 0;
  logic [AW-1:0] e_smp = '0;
  int lat = 5, busy = 1, dly = 2, adc_due = -1, sd_lo = 1, sd_hi = 0, ack_due = -1;
  int en_lo = -1, en_hi = -1, rst_at = -1;
  bit ack_pend = 0, force_busy = 0, hold_ack = 0, arm_en = 0, arm_rst = 0, rand_off = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  // Phases: 0 idle, 1 awaiting ADC, 2 in SDFT (ready counted from rdy_from), 3 line request
  task automatic model_step(input int c, input bit rs, input bit en, input bit av, input bit rdy,
                            input bit ak, input logic [AW-1:0] ad);
    bit tk;
    if (rs) begin
      run = 0; ph = 0; cnt = 0; e_adc = 0; e_sdft = 0; e_line = 0; e_ovr = 0; e_smp = '0; e_ocnt = 0;
      return;
    end
    tk = en && ((run + 1) % DIV == 0);
    run = en ? run + 1 : 0;
    e_adc = 0;
    e_sdft = 0;
    if (tk && ph != 0 && OVR_EN) begin
      e_ovr = 1;
      if (e_ocnt < OMAX) e_ocnt++;
    end
    if (ph == 0 && tk) begin
      ph = 1; e_adc = 1;
    end else if (ph == 1 && av) begin
      ph = 2; e_sdft = 1; e_smp = ad; rdy_from = c + 3;
    end else if (ph == 2 && c >= rdy_from && rdy) begin
      cnt++;
      ph = cnt == LS ? 3 : 0;
    end else if (ph == 3 && ak) begin
      cnt = 0; ph = 0;
    end
    e_line = ph == 3;
  endtask
  initial begin
    bit rnd, en, av, rdy, ak, rs;
    logic [AW-1:0] ad;
    bus.enable = 0; bus.adc_valid = 0; bus.adc_data = '0; bus.sdft_ready = 1; bus.line_ack = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      cyc = c;
      check("adc_start", bus.adc_start, e_adc);
      check("sdft_start", bus.sdft_start, e_sdft);
      check("sdft_sample", bus.sdft_sample, e_smp);
      check("line_req", bus.line_req, e_line);
      check("overrun", bus.overrun, e_ovr);
      check("overrun_count", bus.overrun_count, e_ocnt);
      if (bus.adc_start === 1'b1) n_adc_dut++;
      if (e_adc) n_adc_exp++;
      rnd = (c >= 300 && c < 1500) || c >= 2900;
      if (c == 1500) force_busy = 1;
      if (c == 1700) hold_ack = 1;
      if (c == 2300) arm_en = 1;
      if (c == 2600) arm_rst = 1;
      if (c >= 800 && c < 1400 && $urandom_range(0, 149) == 0) rand_off = !rand_off;
      if (c == 1400) rand_off = 0;
      if (bus.adc_start === 1'b1) begin
        lat = rnd ? int'($urandom_range(0, 6)) : 5;
        adc_due = c + lat;
        if (arm_en) begin en_lo = c; en_hi = c + 60; arm_en = 0; end
      end
      if (bus.sdft_start === 1'b1) begin
        busy = force_busy ? 30 : !rnd ? 1 :
               $urandom_range(0, 9) == 0 ? int'($urandom_range(10, 25)) : int'($urandom_range(0, 4));
        force_busy = 0;
        sd_lo = c + 2;
        sd_hi = c + 1 + busy;
        if (arm_rst) begin rst_at = c + 1; arm_rst = 0; end
      end
      if (bus.line_req !== 1'b1) ack_pend = 0;
      else if (!ack_pend) begin
        dly = hold_ack ? 300 : rnd ? int'($urandom_range(0, 3)) : 2;
        hold_ack = 0;
        ack_pend = 1;
        ack_due = c + dly;
      end
      rs  = c < 5 || c == rst_at;
      en  = c >= 5 && !(c >= en_lo && c < en_hi) && !rand_off;
      av  = c == adc_due || (rnd && $urandom_range(0, 63) == 0);
      rdy = !(c >= sd_lo && c <= sd_hi);
      ak  = (ack_pend && c == ack_due) || (rnd && $urandom_range(0, 79) == 0);
      if (ak) ack_pend = 0;
      ad  = AW'($urandom);
      reset = rs; bus.enable = en; bus.adc_valid = av; bus.sdft_ready = rdy;
      bus.line_ack = ak; bus.adc_data = ad;
      model_step(c, rs, en, av, rdy, ak, ad);
    end
    check("adc_start_total", n_adc_dut, n_adc_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
